// File: rtl/period_meter_pkg.sv
// Shared types and default constants for the period meter.
package period_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } pm_state_t;

   localparam int unsigned PM_CNT_W       = 32;
   localparam int unsigned PM_TIMEOUT_DEF = 20000000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus history flop; flags rising and falling edges
// of the synchronised level.
module sync_edge_det
   import period_meter_pkg::*;
(
   input  logic clk_in,
   input  logic Res,
   input  logic d_in,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sig_s;
   logic sig_d;

   // Synchroniser chain and one-cycle history of the synchronised level
   always_ff @(posedge clk_in) begin
      if (Res) begin
         meta  <= 1'b0;
         sig_s <= 1'b0;
         sig_d <= 1'b0;
      end else begin
         meta  <= d_in;
         sig_s <= meta;
         sig_d <= sig_s;
      end
   end

   assign lvl  = sig_s;
   assign rise = sig_s & ~sig_d;
   assign fall = ~sig_s & sig_d;

endmodule

// File: rtl/period_meter.sv
// Measures the period (and optionally high time) of a slow asynchronous
// square wave in clk_in cycles, with a sticky no-edge timeout.
// Optional feature macro: PERIOD_METER_DUTY_EN builds the high-time counter;
// without it high_out is tied to 0.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned          CNT_W       = PM_CNT_W,
   parameter logic [CNT_W-1:0]     TIMEOUT_CYC = CNT_W'(PM_TIMEOUT_DEF)
) (
   input  logic             clk_in,
   input  logic             Res,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             period_vld,
   output logic             timeout,
   output logic             busy
);

   pm_state_t        state;
   pm_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             vld_nxt;
   logic             timeout_nxt;
   logic             busy_nxt;
   logic             lvl;
   logic             rise;
   logic             fall;
   logic             unused_fall;

   // High time is counted from the level itself; the fall strobe is spare
   assign unused_fall = fall;

   sync_edge_det u_sync (
      .clk_in (clk_in),
      .Res    (Res),
      .d_in   (sig_in),
      .lvl    (lvl),
      .rise   (rise),
      .fall   (fall)
   );

   // State, period counter and registered outputs
   always_ff @(posedge clk_in) begin
      if (Res) begin
         state      <= IDLE;
         cnt        <= '0;
         period_out <= '0;
         period_vld <= 1'b0;
         timeout    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         period_out <= period_nxt;
         period_vld <= vld_nxt;
         timeout    <= timeout_nxt;
         busy       <= busy_nxt;
      end
   end

   // Next-state and output decode; a rise wins over a same-cycle timeout
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      period_nxt  = period_out;
      vld_nxt     = 1'b0;
      timeout_nxt = timeout;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = MEAS;
               cnt_nxt   = CNT_W'(1);
            end
         end
         MEAS: begin
            if (rise) begin
               period_nxt  = cnt;
               vld_nxt     = 1'b1;
               timeout_nxt = 1'b0;
               cnt_nxt     = CNT_W'(1);
            end else if (cnt == TIMEOUT_CYC) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt == MEAS);
   end

`ifdef PERIOD_METER_DUTY_EN
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] hcnt_nxt;
   logic [CNT_W-1:0] high_q;
   logic [CNT_W-1:0] high_nxt;

   // High-time counter; once the level drops it cannot rise again without a rise strobe
   always_comb begin
      hcnt_nxt = hcnt;
      high_nxt = high_q;
      if (rise) begin
         if (state == MEAS) begin
            high_nxt = hcnt;
         end
         hcnt_nxt = CNT_W'(1);
      end else if ((state == MEAS) && (cnt != TIMEOUT_CYC) && lvl) begin
         hcnt_nxt = hcnt + CNT_W'(1);
      end
   end

   // High-time registers
   always_ff @(posedge clk_in) begin
      if (Res) begin
         hcnt   <= '0;
         high_q <= '0;
      end else begin
         hcnt   <= hcnt_nxt;
         high_q <= high_nxt;
      end
   end

   assign high_out = high_q;
`else
   assign high_out = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter with TIMEOUT_CYC = 100.
module tb_period_meter;

   localparam int unsigned CNT_W = 32;
`ifdef PERIOD_METER_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   typedef struct {
      int unsigned per;
      int unsigned hi;
   } exp_t;

   logic             clk_in;
   logic             Res;
   logic             sig_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             period_vld;
   logic             timeout;
   logic             busy;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   prev_vld = 1'b0;

   period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (32'd100)
   ) dut (
      .clk_in     (clk_in),
      .Res        (Res),
      .sig_in     (sig_in),
      .period_out (period_out),
      .high_out   (high_out),
      .period_vld (period_vld),
      .timeout    (timeout),
      .busy       (busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic int unsigned hexp(input int unsigned h);
      return DUTY ? h : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // One rising edge, held high for hi cycles then low for lo cycles
   task automatic rise_then(input int hi, input int lo, input bit push,
                            input int unsigned ep, input int unsigned eh);
      exp_t e;
      if (push) begin
         e.per = ep;
         e.hi  = hexp(eh);
         exp_q.push_back(e);
      end
      sig_in = 1'b1;
      cyc(hi);
      sig_in = 1'b0;
      cyc(lo);
   endtask

   // Monitor: pop and compare on every strobe
   always @(negedge clk_in) begin
      exp_t e;
      if (period_vld) begin
         chk("vld_single_cycle", {31'b0, prev_vld}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=%0d required=none", period_out);
         end else begin
            e = exp_q.pop_front();
            chk("period_out", period_out, e.per);
            chk("high_out", high_out, e.hi);
            chk("timeout_at_strobe", {31'b0, timeout}, 32'd0);
         end
      end
      prev_vld = period_vld;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      Res    = 1'b1;
      sig_in = 1'b0;
      cyc(3);
      Res = 1'b0;
      chk("rst_period", period_out, 0);
      chk("rst_high", high_out, 0);
      chk("rst_vld", {31'b0, period_vld}, 0);
      chk("rst_timeout", {31'b0, timeout}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      cyc(2);

      // Scenario 1: period 10, high 4, five periods -> four strobes
      rise_then(4, 6, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) rise_then(4, 6, 1'b1, 10, 4);

      // Scenario 3: held low -> timeout, values held
      cyc(110);
      chk("s3_timeout", {31'b0, timeout}, 1);
      chk("s3_busy_idle", {31'b0, busy}, 0);
      chk("s3_period_held", period_out, 10);
      chk("s3_high_held", high_out, hexp(4));
      rise_then(5, 15, 1'b0, 0, 0);
      chk("s3_timeout_sticky", {31'b0, timeout}, 1);
      chk("s3_busy_meas", {31'b0, busy}, 1);
      rise_then(5, 95, 1'b1, 20, 5);
      chk("s3_timeout_cleared", {31'b0, timeout}, 0);

      // Scenario 4: spacing 100 reports, spacing 101 times out
      rise_then(5, 96, 1'b1, 100, 5);
      rise_then(5, 5, 1'b0, 0, 0);
      chk("s4_timeout_101", {31'b0, timeout}, 1);
      chk("s4_busy_restart", {31'b0, busy}, 1);
      chk("s4_period_held", period_out, 100);

      // Scenario 5: toggle every cycle -> period 2, high 1
      rise_then(1, 1, 1'b1, 10, 5);
      for (int i = 0; i < 5; i++) rise_then(1, 1, 1'b1, 2, 1);
      cyc(5);
      chk("s5_period_last", period_out, 2);

      // Scenario 2: reset, single rise, long low -> no strobe
      Res = 1'b1;
      cyc(2);
      Res = 1'b0;
      chk("s2_rst_period", period_out, 0);
      chk("s2_rst_busy", {31'b0, busy}, 0);
      rise_then(1, 30, 1'b0, 0, 0);
      chk("s2_busy", {31'b0, busy}, 1);
      chk("s2_timeout", {31'b0, timeout}, 0);
      chk("s2_period", period_out, 0);

      // Scenario 6: reset midway through a period of 10
      rise_then(4, 6, 1'b1, 31, 1);
      rise_then(4, 1, 1'b1, 10, 4);
      Res = 1'b1;
      cyc(1);
      Res = 1'b0;
      chk("s6_rst_period", period_out, 0);
      chk("s6_rst_high", high_out, 0);
      chk("s6_rst_busy", {31'b0, busy}, 0);
      chk("s6_rst_vld", {31'b0, period_vld}, 0);
      cyc(4);
      rise_then(4, 6, 1'b0, 0, 0);
      begin
         exp_t e;
         e.per = 10;
         e.hi  = hexp(4);
         exp_q.push_back(e);
      end
      sig_in = 1'b1;
      cyc(2);
      chk("s6_latency_early", {31'b0, period_vld}, 0);
      cyc(1);
      chk("s6_latency_edge3", {31'b0, period_vld}, 1);
      cyc(1);
      sig_in = 1'b0;
      cyc(10);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of a slow, asynchronous square-wave input in `clk_in` cycles; it is the receive-side counterpart of the team's toggle/blink clock divider. It synchronises `sig_in`, detects rising edges, counts `clk_in` cycles between consecutive rising edges, and publishes each completed measurement with a one-cycle valid strobe. A no-edge timeout flags a dead or stuck input. It sits between the divided-clock or ADC-trigger sources and the status and display logic.

## Interface
- `CNT_W`, 32: width of the period and high-time counters and outputs.
- `TIMEOUT_CYC`, 32'd20000000: maximum accepted period in cycles. Must be ≥ 4 and < 2^CNT_W.
- `clk_in`, in, 1: single system clock; all logic is on its rising edge.
- `Res`, in, 1: reset, synchronous, active-high.
- `sig_in`, in, 1: asynchronous square wave to measure.
- `period_out`, out, CNT_W: last completed period in cycles. Reset value 0.
- `high_out`, out, CNT_W: high time of the last completed period in cycles. Reset value 0.
- `period_vld`, out, 1: one-cycle strobe; `period_out` and `high_out` update in the same cycle. Reset value 0.
- `timeout`, out, 1: sticky no-edge flag. Reset value 0.
- `busy`, out, 1: high while state is MEAS. Reset value 0.

## Operation
- Input path: 2-FF synchroniser produces `sig_s`. A 1-FF history register produces `rise = sig_s & ~sig_d` and `fall = ~sig_s & sig_d`. Reset clears all three flops to 0.
- States:
  - IDLE (reset state): waiting for the first edge. On `rise`: go to MEAS, set `cnt` = 1, set `hcnt` = 1.
  - MEAS, on `rise`:
    - `period_out` ← `cnt`, `high_out` ← `hcnt`.
    - Pulse `period_vld`, clear `timeout`.
    - Set `cnt` = 1 and `hcnt` = 1; stay in MEAS.
  - MEAS, otherwise:
    - `cnt` ← `cnt`+1.
    - `hcnt` ← `hcnt`+1 while `sig_s` = 1 and no `fall` has occurred since the last `rise`; after a `fall`, `hcnt` holds.
  - MEAS, timeout: if there is no `rise` and `cnt` == `TIMEOUT_CYC`, go to IDLE and set `timeout` = 1. `period_out` and `high_out` hold their old values, and `period_vld` stays 0.
- Result: rising edges N cycles apart report `period_out` = N. The minimum reportable value is 2.
- Simultaneous events: a `rise` in the same cycle that `cnt` reaches `TIMEOUT_CYC` counts as a valid measurement. It reports `TIMEOUT_CYC` with no timeout.
- Arithmetic:
  - `cnt` never exceeds `TIMEOUT_CYC`, so it never wraps.
  - `hcnt` ≤ `cnt` always.
  - All counters are unsigned CNT_W wide.
- Reset mid-measurement: `Res` has priority over every transition. The state returns to IDLE and all outputs and counters clear. The in-progress partial period is discarded; the first period after reset needs two rising edges.

## Timing
- Latency from a `sig_in` rising transition to `period_vld`: 3 `clk_in` edges (2 synchroniser stages plus the registered output).
- `period_vld` is high for exactly 1 cycle per completed period, never on two consecutive cycles.
- `timeout` rises in the cycle after `cnt` == `TIMEOUT_CYC` is evaluated. It stays high until the next `period_vld` or until `Res`.
- `busy` is a registered decode of state MEAS.

## Configuration
- Macro `PERIOD_METER_DUTY_EN`.
- When defined: the `hcnt` counter is built, and `high_out` carries the measured high time.
- When undefined: `hcnt` is not built and `high_out` is tied to 0. The port list does not change, and the period behaviour is identical.

## Structure
- Package `period_meter_pkg` holds:
  - state enum `pm_state_t` {IDLE, MEAS};
  - default constants `PM_CNT_W` = 32 and `PM_TIMEOUT_DEF` = 20000000.
- One sub-module, `sync_edge_det`: 2-FF synchroniser plus history flop. Ports: `clk_in`, `Res`, `d_in`, `lvl`, `rise`, `fall`.
- The FSM, counters and output registers live in `period_meter`.

## Test plan
Run scenarios 1, 3, 4 and 5 with `TIMEOUT_CYC` = 100.
- Scenario 1: `sig_in` with period 10 (high 4, low 6), 5 periods -> 4 `period_vld` pulses, each with `period_out` = 10 and `high_out` = 4. With the macro undefined, `high_out` = 0.
- Scenario 2: after reset, a single rising edge followed by low for 30 cycles -> no `period_vld`, `busy` = 1, `timeout` = 0.
- Scenario 3: periodic edges then `sig_in` held low -> `timeout` = 1 after 100 cycles without a rise. State returns to IDLE, `period_out` keeps its last value. Two new edges 20 cycles apart -> `period_out` = 20, `timeout` clears with the strobe.
- Scenario 4: rising edges exactly 100 cycles apart -> `period_out` = 100 and `timeout` stays 0. Edges 101 cycles apart -> timeout, no strobe.
- Scenario 5: `sig_in` toggling every cycle (period 2) -> `period_out` = 2, `high_out` = 1, strobe every 2 cycles.
- Scenario 6: assert `Res` for 1 cycle midway through a period of 10 -> all outputs 0 in the next cycle. The first strobe comes one full period after the next rise, with value 10.
